cond_status_unit: RTL and testbench
===================================

COND_STATUS_UNIT -- requirements
Module: cond_status_unit

Interface
REQ-001 Parameter NUM_CTX, default 4: number of independent status-flag contexts; legal range 1..16.
REQ-002 Parameter CTX_W, default 2: context index width; CTX_W = max(1, clog2(NUM_CTX)).
REQ-003 Parameter CNT_W, default 16: width of the execute and skip counters.
REQ-004 Parameter NV_AS_AL, default 0: selects condition 4'b1111 behaviour (0 = never, 1 = always).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 validIn  in  1  an instruction condition is presented this cycle.
REQ-008 ctxIn  in  CTX_W  context of the presented instruction.
REQ-009 condIn  in  4  ARM condition field of the presented instruction.
REQ-010 stall  in  1  hold the output stage.
REQ-011 flush  in  1  kill the output stage.
REQ-012 statusWe  in  1  write flags into a context this cycle.
REQ-013 statusCtx  in  CTX_W  context written by statusWe.
REQ-014 statusIn  in  4  new flags {n,z,c,v}.
REQ-015 validOut  out  1  output stage holds a valid result.
REQ-016 condOut  out  1  registered pass/fail of the held instruction.
REQ-017 ctxOut  out  CTX_W  context of the held instruction.
REQ-018 statusOut  out  4  combinational effective flags for ctxIn (after bypass).
REQ-019 execCount  out  CNT_W  saturating count of passed conditions.
REQ-020 skipCount  out  CNT_W  saturating count of failed conditions.

Function
REQ-021 Each context SHALL hold a 4-bit flag register {n,z,c,v}; on a clock edge with statusWe=1, flags[statusCtx] <= statusIn, independent of stall and flush.
REQ-022 Effective flags SHALL be statusIn when statusWe=1 and statusCtx==ctxIn, else flags[ctxIn] (same-cycle bypass).
REQ-023 Evaluation SHALL use effective flags: 0000 z; 0001 ~z; 0010 c; 0011 ~c; 0100 n; 0101 ~n; 0110 v; 0111 ~v; 1000 c&~z; 1001 ~c|z; 1010 n==v; 1011 n!=v; 1100 ~z&(n==v); 1101 z|(n!=v); 1110 1; 1111 NV_AS_AL.
REQ-024 Evaluation result SHALL never be X for any condIn value.
REQ-025 ctxIn >= NUM_CTX SHALL read flags as 4'b0000 and SHALL not alias another context; statusCtx >= NUM_CTX writes SHALL be ignored.
REQ-026 Latency SHALL be 1 cycle: the result for an input accepted at edge k appears on validOut/condOut/ctxOut after edge k.
REQ-027 Priority per edge SHALL be flush > stall > load.
REQ-028 flush=1: validOut <= 0, condOut <= 0; ctxOut holds; counters unchanged.
REQ-029 stall=1 (flush=0): validOut, condOut, ctxOut hold; input is not accepted; counters unchanged.
REQ-030 Load (flush=0, stall=0): validOut <= validIn, ctxOut <= ctxIn, condOut <= validIn & eval.
REQ-031 On load with validIn=1, execCount SHALL increment if eval=1, else skipCount SHALL increment; each saturates at 2^CNT_W-1.
REQ-032 A flag write and a condition read of the same context on the same edge SHALL evaluate with the new flags (REQ-022), and the flag register SHALL also take the new value.

Reset
REQ-033 rst=0 SHALL immediately clear all flag registers to 4'b0000, validOut, condOut to 0, ctxOut to 0, execCount and skipCount to 0, regardless of clk.
REQ-034 While rst=0 no input SHALL be accepted; the first load SHALL occur on the first rising edge with rst=1.
REQ-035 Reset asserted mid-stall or mid-flush SHALL override both.

Verification
REQ-036 Reset, then statusWe=1, statusCtx=1, statusIn=4'b0100; next cycle validIn=1, ctxIn=1, condIn=0000 -> condOut=1, validOut=1, execCount=1; ctxIn=0 same cond -> condOut=0, skipCount=1.
REQ-037 Bypass: flags[2]=0000, same edge statusWe=1, statusCtx=2, statusIn=1001 with validIn=1, ctxIn=2, condIn=1010 (GE) -> condOut=1; statusOut=1001 before edge.
REQ-038 stall=1 and flush=1 together with validIn=1 -> validOut=0, counters unchanged; stall alone for 3 cycles -> outputs held, counters unchanged.
REQ-039 condIn=1111 with NV_AS_AL=0 -> condOut=0, skipCount++; with NV_AS_AL=1 -> condOut=1, execCount++; CNT_W=2, 5 passing loads -> execCount=3.
REQ-040 rst pulsed low between edges while validOut=1 -> all outputs and counters 0 immediately, flags read 0000 afterwards; sweep all 16 conditions x 16 flag values against REQ-023 table.

Source files
------------

// File: rtl/cond_status_unit.sv
// Per-context ARM condition-code evaluator with a single registered output stage.
// Each context holds {n,z,c,v}; a same-cycle flag write is bypassed into the evaluation.
module cond_status_unit #(
    parameter int NUM_CTX  = 4,
    parameter int CTX_W    = 2,
    parameter int CNT_W    = 16,
    parameter int NV_AS_AL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validIn,
    input  logic [CTX_W-1:0] ctxIn,
    input  logic [3:0]       condIn,
    input  logic             stall,
    input  logic             flush,
    input  logic             statusWe,
    input  logic [CTX_W-1:0] statusCtx,
    input  logic [3:0]       statusIn,
    output logic             validOut,
    output logic             condOut,
    output logic [CTX_W-1:0] ctxOut,
    output logic [3:0]       statusOut,
    output logic [CNT_W-1:0] execCount,
    output logic [CNT_W-1:0] skipCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0]       r_flags [NUM_CTX];
    logic             r_valid;
    logic             r_cond;
    logic [CTX_W-1:0] r_ctx;
    logic [CNT_W-1:0] r_exec;
    logic [CNT_W-1:0] r_skip;

    logic       w_ctx_ok;
    logic       w_bypass;
    logic [3:0] w_stored;
    logic [3:0] w_eff;
    logic       w_eval;
    logic       w_n, w_z, w_c, w_v;
    logic       w_load;

    // Out-of-range contexts match no flag register, so they read as zero.
    always_comb begin
        w_stored = 4'b0000;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (32'(ctxIn) == i) w_stored = r_flags[i];
        end
    end

    assign w_ctx_ok  = (32'(ctxIn) < NUM_CTX);
    assign w_bypass  = statusWe && (statusCtx == ctxIn) && w_ctx_ok;
    assign w_eff     = w_bypass ? statusIn : w_stored;
    assign statusOut = w_eff;
    assign {w_n, w_z, w_c, w_v} = w_eff;

    always_comb begin
        w_eval = 1'b0;
        case (condIn)
            4'b0000: w_eval = w_z;
            4'b0001: w_eval = ~w_z;
            4'b0010: w_eval = w_c;
            4'b0011: w_eval = ~w_c;
            4'b0100: w_eval = w_n;
            4'b0101: w_eval = ~w_n;
            4'b0110: w_eval = w_v;
            4'b0111: w_eval = ~w_v;
            4'b1000: w_eval = w_c & ~w_z;
            4'b1001: w_eval = ~w_c | w_z;
            4'b1010: w_eval = (w_n == w_v);
            4'b1011: w_eval = (w_n != w_v);
            4'b1100: w_eval = ~w_z & (w_n == w_v);
            4'b1101: w_eval = w_z | (w_n != w_v);
            4'b1110: w_eval = 1'b1;
            default: w_eval = (NV_AS_AL != 0);
        endcase
    end

    // Flag writes ignore stall/flush; writes to nonexistent contexts are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CTX; i++) r_flags[i] <= 4'b0000;
        end else begin
            for (int i = 0; i < NUM_CTX; i++) begin
                if (statusWe && (32'(statusCtx) == i)) r_flags[i] <= statusIn;
            end
        end
    end

    assign w_load = !flush && !stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_cond  <= 1'b0;
            r_ctx   <= '0;
            r_exec  <= '0;
            r_skip  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_cond  <= 1'b0;
        end else if (w_load) begin
            r_valid <= validIn;
            r_ctx   <= ctxIn;
            r_cond  <= validIn & w_eval;
            if (validIn && w_eval && (r_exec != CNT_MAX)) r_exec <= r_exec + CNT_ONE;
            if (validIn && !w_eval && (r_skip != CNT_MAX)) r_skip <= r_skip + CNT_ONE;
        end
    end

    assign validOut  = r_valid;
    assign condOut   = r_cond;
    assign ctxOut    = r_ctx;
    assign execCount = r_exec;
    assign skipCount = r_skip;

endmodule

// File: tb/tb_cond_status_unit.sv
// Scoreboard bench: the driver pushes model predictions, a monitor compares after each edge.
// u_a uses defaults; u_b has 3 contexts (ctx 3 out of range), 2-bit counters and NV as always.
module tb_cond_status_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       validIn = 1'b0, stall = 1'b0, flush = 1'b0, statusWe = 1'b0;
    logic [1:0] ctxIn = '0, statusCtx = '0;
    logic [3:0] condIn = '0, statusIn = '0;

    logic        a_valid, a_cond, b_valid, b_cond;
    logic [1:0]  a_ctx, b_ctx;
    logic [3:0]  a_stat, b_stat;
    logic [15:0] a_exec, a_skip;
    logic [1:0]  b_exec, b_skip;

    cond_status_unit #(.NUM_CTX(4), .CTX_W(2), .CNT_W(16), .NV_AS_AL(0)) u_a (
        .clk(clk), .rst(rst), .validIn(validIn), .ctxIn(ctxIn), .condIn(condIn),
        .stall(stall), .flush(flush), .statusWe(statusWe), .statusCtx(statusCtx),
        .statusIn(statusIn), .validOut(a_valid), .condOut(a_cond), .ctxOut(a_ctx),
        .statusOut(a_stat), .execCount(a_exec), .skipCount(a_skip));

    cond_status_unit #(.NUM_CTX(3), .CTX_W(2), .CNT_W(2), .NV_AS_AL(1)) u_b (
        .clk(clk), .rst(rst), .validIn(validIn), .ctxIn(ctxIn), .condIn(condIn),
        .stall(stall), .flush(flush), .statusWe(statusWe), .statusCtx(statusCtx),
        .statusIn(statusIn), .validOut(b_valid), .condOut(b_cond), .ctxOut(b_ctx),
        .statusOut(b_stat), .execCount(b_exec), .skipCount(b_skip));

    always #5 clk = ~clk;

    typedef struct {
        bit v; bit c; int ctx; int e; int s;
    } out_t;
    typedef struct {
        out_t a; out_t b;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rst_drv  = 1'b0;

    // Reference model: flags per context plus the visible output state of each instance.
    bit [3:0] fa[4];
    bit [3:0] fb[4];
    out_t     ma, mb;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit cond_holds(input bit [3:0] cond, input bit [3:0] f, input bit nv_al);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return nv_al;
        endcase
    endfunction

    function automatic bit [3:0] eff_flags(input bit [3:0] stored, input int num, input int ctx,
                                           input bit we, input int sctx, input bit [3:0] sin);
        if (ctx >= num) return 4'b0000;
        if (we && sctx == ctx) return sin;
        return stored;
    endfunction

    function automatic out_t next_out(input out_t cur, input bit st, input bit fl, input bit vin,
                                      input int ctx, input bit ev, input int cmax);
        out_t r = cur;
        if (fl) begin
            r.v = 0; r.c = 0;
        end else if (!st) begin
            r.v = vin; r.ctx = ctx; r.c = vin && ev;
            if (vin && ev && r.e < cmax) r.e++;
            if (vin && !ev && r.s < cmax) r.s++;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin fa[i] = 0; fb[i] = 0; end
        ma = '{0, 0, 0, 0, 0};
        mb = '{0, 0, 0, 0, 0};
    endtask

    task automatic step(input bit vin, input int ctx, input bit [3:0] cond, input bit st,
                        input bit fl, input bit we, input int sctx, input bit [3:0] sin);
        bit [3:0] ea, eb;
        exp_t x;
        @(negedge clk);
        rst = rst_drv;
        validIn = vin; ctxIn = 2'(ctx); condIn = cond; stall = st; flush = fl;
        statusWe = we; statusCtx = 2'(sctx); statusIn = sin;
        #1;
        ea = eff_flags(fa[ctx], 4, ctx, we, sctx, sin);
        eb = eff_flags(fb[ctx], 3, ctx, we, sctx, sin);
        chk("a_statusOut", int'(a_stat), int'(ea));
        chk("b_statusOut", int'(b_stat), int'(eb));
        if (!rst_drv) begin
            model_reset();
        end else begin
            ma = next_out(ma, st, fl, vin, ctx, cond_holds(cond, ea, 1'b0), 65535);
            mb = next_out(mb, st, fl, vin, ctx, cond_holds(cond, eb, 1'b1), 3);
            if (we) fa[sctx] = sin;
            if (we && sctx < 3) fb[sctx] = sin;
        end
        x.a = ma; x.b = mb;
        q.push_back(x);
    endtask

    // Monitor: one comparison set per edge for which the driver issued a prediction.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            chk("a_validOut", int'(a_valid), int'(x.a.v));
            chk("a_condOut",  int'(a_cond),  int'(x.a.c));
            chk("a_ctxOut",   int'(a_ctx),   x.a.ctx);
            chk("a_execCount", int'(a_exec), x.a.e);
            chk("a_skipCount", int'(a_skip), x.a.s);
            chk("b_validOut", int'(b_valid), int'(x.b.v));
            chk("b_condOut",  int'(b_cond),  int'(x.b.c));
            chk("b_ctxOut",   int'(b_ctx),   x.b.ctx);
            chk("b_execCount", int'(b_exec), x.b.e);
            chk("b_skipCount", int'(b_skip), x.b.s);
            $display("edge t=%0t a{v=%0d c=%0d ctx=%0d e=%0d s=%0d} b{v=%0d c=%0d ctx=%0d e=%0d s=%0d}",
                     $time, a_valid, a_cond, a_ctx, a_exec, a_skip, b_valid, b_cond, b_ctx, b_exec, b_skip);
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_a_valid"}, int'(a_valid), 0);
        chk({tag, "_a_cond"},  int'(a_cond), 0);
        chk({tag, "_a_ctx"},   int'(a_ctx), 0);
        chk({tag, "_a_exec"},  int'(a_exec), 0);
        chk({tag, "_a_skip"},  int'(a_skip), 0);
        chk({tag, "_b_valid"}, int'(b_valid), 0);
        chk({tag, "_b_exec"},  int'(b_exec), 0);
        chk({tag, "_b_skip"},  int'(b_skip), 0);
    endtask

    // Assert reset between edges and confirm the outputs clear without a clock edge.
    task automatic mid_cycle_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        rst_drv = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        step(1, 1, 4'd14, 0, 0, 1, 1, 4'hF);
        rst_drv = 1'b1;
    endtask

    initial begin
        int wait_cnt;
        model_reset();
        #2;
        check_all_zero("por");
        step(1, 1, 4'd14, 0, 0, 0, 0, 4'h0);
        rst_drv = 1'b1;

        // Write Z=... {n,z,c,v}=0100 into ctx 1, then EQ on ctx 1 passes and on ctx 0 fails.
        step(0, 0, 4'd0, 0, 0, 1, 1, 4'b0100);
        step(1, 1, 4'd0, 0, 0, 0, 0, 4'h0);
        @(posedge clk); #2;
        chk("eq_ctx1_cond", int'(a_cond), 1);
        chk("eq_ctx1_exec", int'(a_exec), 1);
        step(1, 0, 4'd0, 0, 0, 0, 0, 4'h0);
        @(posedge clk); #2;
        chk("eq_ctx0_cond", int'(a_cond), 0);
        chk("eq_ctx0_skip", int'(a_skip), 1);

        // Same-edge bypass: GE on ctx 2 sees the flags written this cycle.
        step(0, 0, 4'd0, 0, 0, 1, 2, 4'b0000);
        step(1, 2, 4'b1010, 0, 0, 1, 2, 4'b1001);
        @(posedge clk); #2;
        chk("bypass_ge_cond", int'(a_cond), 1);

        // Stall+flush together, then stall alone for three cycles.
        step(1, 3, 4'd14, 1, 1, 0, 0, 4'h0);
        step(1, 1, 4'd14, 0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 3; i++) step(1, 0, 4'd15, 1, 0, 0, 0, 4'h0);

        // NV condition: never on u_a, always on u_b; five passes saturate u_b.execCount.
        step(1, 0, 4'd15, 0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 5; i++) step(1, 1, 4'd15, 0, 0, 0, 0, 4'h0);

        // Out-of-range context on u_b, including a write that must be dropped.
        step(1, 3, 4'd0, 0, 0, 1, 3, 4'b0100);
        step(1, 3, 4'd1, 0, 0, 0, 0, 4'h0);

        mid_cycle_reset();
        for (int c = 0; c < 4; c++) step(1, c, 4'd1, 0, 0, 0, 0, 4'h0);

        // Full condition x flag-value sweep via the bypass path on ctx 0.
        for (int f = 0; f < 16; f++)
            for (int c = 0; c < 16; c++)
                step(1, 0, 4'(c), 0, 0, 1, 0, 4'(f));

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3), 4'($urandom_range(0, 15)));
            if (i == 700) mid_cycle_reset();
        end

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk); #2;
            wait_cnt++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
